edge_generator: RTL and testbench

- Transmit-side counterpart of the input edge-detection path. It drives a bus line with a burst of N clean pulses at a programmable half-period, referenced to sys_clk.
- It also emits one-cycle rise/fall strobes in step with each output transition, so downstream logic (e.g. data shifters for injected SPI/UART-style traffic) can act on exact edges.
- Sits between the MITM injection logic and the output pin driver.

---
 rtl/edge_generator_if.sv | 21 ++
 rtl/edge_generator.sv | 142 ++++++++++++++
 tb/tb_edge_generator.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_generator_if.sv
// Bus bundle between the injection logic (master) and the edge generator (slave).
interface edge_generator_if;
    logic       start;
    logic [7:0] num_pulses;
    logic       abort;
    logic       sig_out;
    logic       rise_edge;
    logic       fall_edge;
    logic       busy;
    logic       done;

    modport master (
        output start, num_pulses, abort,
        input  sig_out, rise_edge, fall_edge, busy, done
    );

    modport slave (
        input  start, num_pulses, abort,
        output sig_out, rise_edge, fall_edge, busy, done
    );
endinterface

// File: rtl/edge_generator.sv
// Burst pulse generator: emits num_pulses clean pulses at a programmable
// half-period, with one-cycle rise/fall strobes registered alongside each
// line transition and a one-cycle done strobe after a trailing guard hold.
module edge_generator #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CTR_WIDTH   = 8,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input logic             sys_clk,
    input logic             rst,
    edge_generator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GUARD
    } state_t;

    localparam logic [CTR_WIDTH-1:0] LP_LAST = CTR_WIDTH'(HALF_PERIOD - 1);

    state_t               r_state;
    logic [CTR_WIDTH-1:0] r_ctr;
    logic [7:0]           r_remaining;
    logic                 r_sig;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_busy;
    logic                 r_done;

    state_t               w_state;
    logic [CTR_WIDTH-1:0] w_ctr;
    logic [7:0]           w_remaining;
    logic                 w_sig;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_ctr_last;

    assign w_ctr_last = (r_ctr == LP_LAST);

    // State and all outputs are registered; reset returns the line to idle at once.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_remaining <= '0;
            r_sig       <= IDLE_LEVEL;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ctr       <= w_ctr;
            r_remaining <= w_remaining;
            r_sig       <= w_sig;
            r_rise      <= w_rise;
            r_fall      <= w_fall;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    // Next-state, half-period timing, pulse counting and strobe generation.
    always_comb begin
        w_state     = r_state;
        w_ctr       = r_ctr;
        w_remaining = r_remaining;
        w_sig       = r_sig;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_busy      = r_busy;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_pulses != 8'd0) begin
                        w_remaining = bus.num_pulses;
                        w_ctr       = '0;
                        w_busy      = 1'b1;
                        w_state     = S_ACTIVE;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end

            S_ACTIVE: begin
                if (bus.abort) begin
                    // Abort outranks a coincident toggle: only a return-to-idle strobe can fire.
                    w_sig   = IDLE_LEVEL;
                    w_ctr   = '0;
                    w_state = S_GUARD;
                    if (r_sig != IDLE_LEVEL) begin
                        w_rise = IDLE_LEVEL;
                        w_fall = ~IDLE_LEVEL;
                    end
                end else if (w_ctr_last) begin
                    w_ctr  = '0;
                    w_sig  = ~r_sig;
                    w_rise = ~r_sig;
                    w_fall = r_sig;
                    if (r_sig != IDLE_LEVEL) begin
                        if (r_remaining != 8'd0) begin
                            w_remaining = r_remaining - 8'd1;
                        end
                        if (r_remaining <= 8'd1) begin
                            w_state = S_GUARD;
                        end
                    end
                end else begin
                    w_ctr = r_ctr + CTR_WIDTH'(1);
                end
            end

            S_GUARD: begin
                if (w_ctr_last) begin
                    w_ctr   = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_ctr = r_ctr + CTR_WIDTH'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.sig_out   = r_sig;
    assign bus.rise_edge = r_rise;
    assign bus.fall_edge = r_fall;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench for edge_generator: two instances (idle-low and idle-high),
// expected strobe events are queued when a burst is launched and matched as
// the DUT produces them.
module tb_edge_generator;

    localparam int HP = 4;

    logic sys_clk = 1'b0;
    logic rst;

    always #5 sys_clk = ~sys_clk;

    edge_generator_if bus0 ();
    edge_generator_if bus1 ();

    edge_generator #(.HALF_PERIOD(HP), .CTR_WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut0 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus0)
    );

    edge_generator #(.HALF_PERIOD(HP), .CTR_WIDTH(8), .IDLE_LEVEL(1'b1)) u_dut1 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus1)
    );

    // ev encoding: {done, fall_edge, rise_edge}
    typedef struct {
        int         id;
        int         cyc;
        logic [2:0] ev;
    } ev_t;

    ev_t sb_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic idle_of(input int id);
        return (id == 0) ? 1'b0 : 1'b1;
    endfunction

    // Reference burst model: toggles every HP edges after the start edge k,
    // guard of HP edges after the last transition or after an abort.
    task automatic push_burst(input int id, input int k, input int n, input int abort_at);
        logic idl;
        logic lvl;
        int   t;
        idl = idle_of(id);
        lvl = idl;
        if (n == 0) begin
            sb_q.push_back('{id: id, cyc: k, ev: 3'b100});
            return;
        end
        for (int c = 1; c <= 2 * n; c++) begin
            t = k + HP * c;
            if (abort_at >= 0 && abort_at <= t) begin
                if (lvl != idl)
                    sb_q.push_back('{id: id, cyc: abort_at, ev: (idl ? 3'b001 : 3'b010)});
                sb_q.push_back('{id: id, cyc: abort_at + HP, ev: 3'b100});
                return;
            end
            lvl = ~lvl;
            sb_q.push_back('{id: id, cyc: t, ev: (lvl ? 3'b001 : 3'b010)});
        end
        sb_q.push_back('{id: id, cyc: k + HP * (2 * n + 1), ev: 3'b100});
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Called #1 after a posedge; start is sampled on the next edge k.
    task automatic do_start(input int id, input logic [7:0] n, input int ab_rel, output int k);
        k = cyc + 1;
        push_burst(id, k, int'(n), (ab_rel < 0) ? -1 : k + ab_rel);
        if (id == 0) begin
            bus0.start = 1'b1; bus0.num_pulses = n;
        end else begin
            bus1.start = 1'b1; bus1.num_pulses = n;
        end
        @(posedge sys_clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check("busy_after_start", (id == 0) ? bus0.busy : bus1.busy, (n != 8'd0));
    endtask

    // Abort sampled on edge a.
    task automatic pulse_abort(input int id, input int a);
        wait_until(a - 1);
        if (id == 0) bus0.abort = 1'b1;
        else         bus1.abort = 1'b1;
        @(posedge sys_clk);
        #1;
        bus0.abort = 1'b0;
        bus1.abort = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge sys_clk);
            #1;
        end
        check("drain_timeout", sb_q.size(), 0);
        @(posedge sys_clk);
        #1;
    endtask

    // Monitor: match every strobe against the scoreboard; flag overdue entries.
    always @(negedge sys_clk) begin
        if (rst === 1'b1) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check("missed_event", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            for (int d = 0; d < 2; d++) begin
                logic [2:0] ev;
                logic       sig;
                logic       bsy;
                logic       lvl_exp;
                ev_t        e;
                ev  = (d == 0) ? {bus0.done, bus0.fall_edge, bus0.rise_edge}
                               : {bus1.done, bus1.fall_edge, bus1.rise_edge};
                sig = (d == 0) ? bus0.sig_out : bus1.sig_out;
                bsy = (d == 0) ? bus0.busy : bus1.busy;
                if (ev != 3'b000) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_event", ev, 3'b000);
                    end else begin
                        e = sb_q.pop_front();
                        check("ev_dut", d, e.id);
                        check("ev_cycle", cyc, e.cyc);
                        check("ev_kind", ev, e.ev);
                        lvl_exp = e.ev[0] ? 1'b1 : (e.ev[1] ? 1'b0 : idle_of(d));
                        check("ev_level", sig, lvl_exp);
                        if (e.ev[2]) check("busy_at_done", bsy, 1'b0);
                    end
                end
            end
        end
    end

    int k;

    initial begin
        rst = 1'b0;
        bus0.start = 1'b0; bus0.num_pulses = '0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.num_pulses = '0; bus1.abort = 1'b0;
        #12;
        check("rst_sig0", bus0.sig_out, 1'b0);
        check("rst_sig1", bus1.sig_out, 1'b1);
        check("rst_outs0", {bus0.rise_edge, bus0.fall_edge, bus0.busy, bus0.done}, 4'b0000);
        check("rst_outs1", {bus1.rise_edge, bus1.fall_edge, bus1.busy, bus1.done}, 4'b0000);
        @(posedge sys_clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;

        // Basic 3-pulse burst; abort during the guard hold must change nothing.
        do_start(0, 8'd3, -1, k);
        pulse_abort(0, k + 26);
        drain();

        // Inverted polarity, single pulse.
        do_start(1, 8'd1, -1, k);
        drain();
        check("idle_high_after", bus1.sig_out, 1'b1);

        // Zero-count request: done only.
        do_start(0, 8'd0, -1, k);
        drain();

        // Abort in IDLE: no effect.
        pulse_abort(0, cyc + 1);
        check("abort_idle_busy", bus0.busy, 1'b0);
        check("abort_idle_sig", bus0.sig_out, 1'b0);

        // Abort with line high, abort coinciding with rise, abort coinciding with fall.
        do_start(0, 8'd5, 14, k);
        pulse_abort(0, k + 14);
        drain();
        do_start(0, 8'd5, 12, k);
        pulse_abort(0, k + 12);
        drain();
        do_start(0, 8'd5, 16, k);
        pulse_abort(0, k + 16);
        drain();
        do_start(1, 8'd3, 6, k);
        pulse_abort(1, k + 6);
        drain();

        // Start during a burst is ignored; restart on the edge after done is taken.
        do_start(0, 8'd2, -1, k);
        wait_until(k + 5);
        bus0.start = 1'b1; bus0.num_pulses = 8'd7;
        @(posedge sys_clk);
        #1;
        bus0.start = 1'b0;
        check("ignored_start_busy", bus0.busy, 1'b1);
        wait_until(k + 20);
        do_start(0, 8'd2, -1, k);
        drain();

        // Asynchronous reset mid-burst.
        do_start(0, 8'd3, -1, k);
        wait_until(k + 9);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_sig", bus0.sig_out, 1'b0);
        check("midrst_outs", {bus0.rise_edge, bus0.fall_edge, bus0.busy, bus0.done}, 4'b0000);
        sb_q.delete();
        @(posedge sys_clk);
        #1;
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        do_start(0, 8'd2, -1, k);
        drain();

        // Maximum count, no wrap.
        do_start(1, 8'd255, -1, k);
        drain();

        check("final_queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
